// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage: owns the program counter, issues word reads to instruction
//   memory over a req/ack handshake of variable latency, and buffers fetched
//   words with their PCs in a 2-entry queue. Redirects from execute flush the
//   queue. A read that is still in flight at a redirect is waited out and its
//   data dropped. A misaligned redirect target raises a sticky fault and halts
//   fetching until reset.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  read request and byte address (word aligned)
//   imem_ack/imem_rdata read completion and instruction word
//   redirect_valid/pc   one-cycle redirect pulse and target
//   stall               decode not ready (head is not consumed)
//   instr_valid/instr/instr_pc  queue head towards decode
//   fault               sticky misaligned-redirect error
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] req_addr_r;
    logic        pend_r;
    logic        fault_r;
    logic [1:0]  count_r;
    logic [31:0] q_instr_r [0:1];
    logic [31:0] q_pc_r    [0:1];

    logic        slot_free_s;
    logic        start_s;
    logic        req_s;
    logic [31:0] addr_s;
    logic        fire_s;
    logic        redir_s;
    logic        redir_bad_s;
    logic        push_s;
    logic        pop_s;

    // Handshake and queue control decoded from current state and inputs.
    // imem_req must rise in the very cycle reset is released and a consume in
    // the same cycle frees a slot, so the request is decoded combinationally.
    always_comb begin
        slot_free_s = (count_r != 2'd2) || !stall;
        // No new read is launched in a redirect cycle: the old PC is stale.
        start_s     = (state_r == ST_FETCH) && !pend_r && !redirect_valid && slot_free_s;
        req_s       = !rst && (pend_r || start_s);
        if (rst) begin
            addr_s = RESET_PC;
        end else if (pend_r) begin
            addr_s = req_addr_r;
        end else begin
            addr_s = pc_r;
        end
        fire_s      = req_s && imem_ack;
        redir_s     = !rst && redirect_valid && (state_r != ST_HALT);
        redir_bad_s = redir_s && (redirect_pc[1:0] != 2'b00);
        push_s      = fire_s && (state_r == ST_FETCH) && !redirect_valid;
        pop_s       = (count_r != 2'd0) && !stall && !redir_s;
    end

    assign imem_req    = req_s;
    assign imem_addr   = addr_s;
    assign instr_valid = (count_r != 2'd0);
    assign instr       = (count_r != 2'd0) ? q_instr_r[0] : 32'h0000_0000;
    assign instr_pc    = (count_r != 2'd0) ? q_pc_r[0]    : 32'h0000_0000;
    assign fault       = fault_r;

    // PC, FSM, outstanding-request tracking and the 2-entry queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            req_addr_r   <= RESET_PC;
            pend_r       <= 1'b0;
            fault_r      <= 1'b0;
            count_r      <= 2'd0;
            q_instr_r[0] <= 32'h0000_0000;
            q_instr_r[1] <= 32'h0000_0000;
            q_pc_r[0]    <= 32'h0000_0000;
            q_pc_r[1]    <= 32'h0000_0000;
        end else begin
            // A raised request is held with its address until acked.
            pend_r <= req_s && !imem_ack;
            if (req_s) begin
                req_addr_r <= addr_s;
            end
            if (redir_s) begin
                count_r <= 2'd0;
                if (redir_bad_s) begin
                    fault_r <= 1'b1;
                    state_r <= ST_HALT;
                end else begin
                    pc_r    <= redirect_pc;
                    state_r <= (pend_r && !imem_ack) ? ST_DISCARD : ST_FETCH;
                end
            end else begin
                case (state_r)
                    ST_FETCH: begin
                        if (push_s) begin
                            pc_r <= pc_r + 32'd4;
                        end
                    end
                    ST_DISCARD: begin
                        if (fire_s) begin
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_HALT: begin
                        state_r <= ST_HALT;
                    end
                    default: begin
                        state_r <= ST_FETCH;
                    end
                endcase
                case ({push_s, pop_s})
                    2'b10: begin
                        q_instr_r[count_r[0]] <= imem_rdata;
                        q_pc_r[count_r[0]]    <= pc_r;
                        count_r               <= count_r + 2'd1;
                    end
                    2'b01: begin
                        q_instr_r[0] <= q_instr_r[1];
                        q_pc_r[0]    <= q_pc_r[1];
                        count_r      <= count_r - 2'd1;
                    end
                    2'b11: begin
                        // Head leaves; new word lands behind whatever remains.
                        if (count_r == 2'd1) begin
                            q_instr_r[0] <= imem_rdata;
                            q_pc_r[0]    <= pc_r;
                        end else begin
                            q_instr_r[0] <= q_instr_r[1];
                            q_pc_r[0]    <= q_pc_r[1];
                            q_instr_r[1] <= imem_rdata;
                            q_pc_r[1]    <= pc_r;
                        end
                    end
                    default: begin
                        count_r <= count_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a bench-side memory with programmable ack
// latency, a queue-based reference model compared every cycle, and directed
// literal expectations taken from the intended timing.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    // second instance exercising PC wrap, always-immediate memory
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        fault2;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int mem_wait = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (mem_wait >= lat);

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) mem_wait <= 0;
        else mem_wait <= mem_wait + 1;
    end

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .fault(fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(mem_word(addr2)),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
        .fault(fault2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq_i[$];
    logic [31:0] mq_p[$];
    logic [31:0] m_pc    = 32'h0000_0000;
    logic [31:0] m_raddr = 32'h0000_0000;
    logic        m_pend  = 1'b0;
    logic        m_disc  = 1'b0;
    logic        m_halt  = 1'b0;
    logic        m_fault = 1'b0;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fire;

    always @(negedge clk) begin
        e_req  = !rst && (m_pend || (!m_halt && !m_disc && !redirect_valid &&
                                     (mq_p.size() < 2 || !stall)));
        e_addr = rst ? 32'h0000_0000 : (m_pend ? m_raddr : m_pc);
        chk("model_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req || rst) chk("model_addr", imem_addr, e_addr);
        chk("model_valid", {31'b0, instr_valid}, {31'b0, (mq_p.size() > 0)});
        chk("model_fault", {31'b0, fault}, {31'b0, m_fault});
        if (mq_p.size() > 0) begin
            chk("model_instr", instr, mq_i[0]);
            chk("model_pc", instr_pc, mq_p[0]);
        end
        // advance to the state after the coming rising edge
        if (rst) begin
            mq_i.delete(); mq_p.delete();
            m_pc = 32'h0000_0000; m_raddr = 32'h0000_0000;
            m_pend = 1'b0; m_disc = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        end else begin
            e_fire = e_req && imem_ack;
            if (redirect_valid && !m_halt) begin
                mq_i.delete(); mq_p.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    m_fault = 1'b1;
                    m_halt  = 1'b1;
                end else begin
                    m_pc   = redirect_pc;
                    m_disc = m_pend && !imem_ack;
                end
            end else begin
                if (mq_p.size() > 0 && !stall) begin
                    mq_i.delete(0); mq_p.delete(0);
                end
                if (e_fire && m_disc) begin
                    m_disc = 1'b0;
                end else if (e_fire && !m_halt) begin
                    mq_i.push_back(mem_word(m_pc));
                    mq_p.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (e_req) m_raddr = e_addr;
            m_pend = e_req && !imem_ack;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 0;
        cyc(); cyc(); #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        // A: immediate acks, no stall
        rst = 1'b0; #1;
        chk("a1_req", {31'b0, imem_req}, 32'd1);
        chk("a1_addr", imem_addr, 32'h0);
        chk("a1_valid", {31'b0, instr_valid}, 32'd0);
        chk("wrap1_addr", addr2, 32'hFFFF_FFF8);
        cyc(); #1;
        chk("a2_valid", {31'b0, instr_valid}, 32'd1);
        chk("a2_pc", instr_pc, 32'h0);
        chk("a2_instr", instr, 32'h0 ^ 32'hDEAD_BEEF);
        chk("wrap2_pc", pc2, 32'hFFFF_FFF8);
        cyc(); #1;
        chk("a3_pc", instr_pc, 32'h4);
        chk("wrap3_pc", pc2, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("a4_pc", instr_pc, 32'h8);
        chk("wrap4_pc", pc2, 32'h0);
        cyc(); #1;
        chk("a5_pc", instr_pc, 32'hC);

        // B: stall for 5 cycles
        cyc(); stall = 1'b1; #1;
        chk("b6_pc", instr_pc, 32'h10);
        chk("b6_addr", imem_addr, 32'h14);
        cyc(); #1;
        chk("b7_req", {31'b0, imem_req}, 32'd0);
        repeat (3) cyc();
        #1;
        chk("b10_req", {31'b0, imem_req}, 32'd0);
        chk("b10_valid", {31'b0, instr_valid}, 32'd1);
        chk("b10_pc", instr_pc, 32'h10);
        cyc(); stall = 1'b0; #1;
        chk("b11_pc", instr_pc, 32'h10);
        chk("b11_req", {31'b0, imem_req}, 32'd1);
        chk("b11_addr", imem_addr, 32'h18);
        cyc(); #1;
        chk("b12_pc", instr_pc, 32'h14);
        cyc(); #1;
        chk("b13_pc", instr_pc, 32'h18);

        // redirect with nothing outstanding
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("r15_req", {31'b0, imem_req}, 32'd1);
        chk("r15_addr", imem_addr, 32'h40);
        chk("r15_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); #1;
        chk("r16_pc", instr_pc, 32'h40);

        // C: 3-cycle-late ack, redirect during the wait
        cyc(); rst = 1'b1; lat = 3; #1;
        cyc(); rst = 1'b0; #1;
        chk("c1_addr", imem_addr, 32'h0);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("c3_req", {31'b0, imem_req}, 32'd1);
        chk("c3_addr", imem_addr, 32'h0);
        chk("c3_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); cyc(); #1;
        chk("c5_req", {31'b0, imem_req}, 32'd1);
        chk("c5_addr", imem_addr, 32'h100);
        chk("c5_valid", {31'b0, instr_valid}, 32'd0);
        repeat (4) cyc();
        #1;
        chk("c9_valid", {31'b0, instr_valid}, 32'd1);
        chk("c9_pc", instr_pc, 32'h100);
        chk("c9_instr", instr, 32'h100 ^ 32'hDEAD_BEEF);

        // D: redirect and ack in the same cycle
        cyc(); rst = 1'b1; lat = 1; #1;
        cyc(); rst = 1'b0; #1;
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("d3_addr", imem_addr, 32'h200);
        chk("d3_req", {31'b0, imem_req}, 32'd1);
        chk("d3_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); cyc(); #1;
        chk("d5_pc", instr_pc, 32'h200);
        chk("d5_instr", instr, 32'h200 ^ 32'hDEAD_BEEF);

        // E: misaligned redirect, halt, reset recovery
        cyc(); rst = 1'b1; lat = 0; #1;
        cyc(); rst = 1'b0; #1;
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
        chk("e2_pc", instr_pc, 32'h0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("e3_fault", {31'b0, fault}, 32'd1);
        chk("e3_valid", {31'b0, instr_valid}, 32'd0);
        chk("e3_req", {31'b0, imem_req}, 32'd0);
        cyc(); cyc(); #1;
        chk("e5_req", {31'b0, imem_req}, 32'd0);
        chk("e5_fault", {31'b0, fault}, 32'd1);
        cyc(); rst = 1'b1; #1;
        cyc(); rst = 1'b0; #1;
        chk("e_rec_fault", {31'b0, fault}, 32'd0);
        chk("e_rec_req", {31'b0, imem_req}, 32'd1);
        chk("e_rec_addr", imem_addr, 32'h0);
        cyc(); #1;
        chk("e_rec_pc0", instr_pc, 32'h0);
        cyc(); #1;
        chk("e_rec_pc4", instr_pc, 32'h4);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage directly upstream of instruction decode and the immediate generator. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. It buffers fetched words with their PCs in a 2-entry queue, so decode back-pressure (`stall`) never drops an instruction. It also applies branch/jump redirects from execute, discarding stale in-flight reads.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word address of the request; byte address, [1:0]=0.
- `imem_ack`  in  1  read done this cycle; `imem_rdata` valid; only meaningful while `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: take `redirect_pc` as next fetch PC.
- `redirect_pc`  in  32  branch/jump target.
- `stall`  in  1  decode not ready; head entry is consumed in a cycle where `instr_valid`=1 and `stall`=0.
- `instr_valid`  out  1  queue head holds a valid instruction.
- `instr`  out  32  queue head instruction word (to decode / immediate generator).
- `instr_pc`  out  32  PC of `instr`.
- `fault`  out  1  sticky misaligned-redirect error.

## Operation
- State: `pc` register, 2-entry queue of {instr, pc}, FSM with states FETCH, DISCARD, HALT.
- FETCH: a new request may start only when the queue has at least 1 free entry, counting an entry freed by a consume in the same cycle.
  - Once `imem_req` rises, it and `imem_addr`=`pc` stay stable until the cycle `imem_ack`=1, regardless of `stall`.
  - At most one outstanding request.
- On ack in FETCH with no redirect: push {`imem_rdata`, `pc`}; `pc` <= `pc`+4.
  - The push is guaranteed a free slot because a request starts only with a free slot.
- `pc`+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Queue: head drives `instr`/`instr_pc`. Push and pop in the same cycle are allowed. Pop on an empty queue is a no-op.
- Redirect (`redirect_valid`=1) with `redirect_pc`[1:0]=0:
  - Flush the queue and set `pc` <= `redirect_pc`.
  - Redirect takes priority over push and pop in that cycle.
  - If a request is outstanding and `imem_ack`=0 that cycle: go to DISCARD.
  - If `imem_ack`=1 in the redirect cycle: drop the data and stay in FETCH.
- DISCARD: keep `imem_req`=1 with the old address until ack; drop the data; then return to FETCH and request `redirect_pc`.
  - A further redirect during DISCARD updates `pc` and stays in DISCARD.
- Redirect with `redirect_pc`[1:0]≠0: set `fault`=1, flush the queue, go to HALT.
  - HALT issues no new requests; an outstanding request is still held to ack and its data dropped.
  - Only `rst` exits HALT.
- `rst` overrides every other input in the same cycle, including mid-transaction. Memory must tolerate a request abandoned by reset.

## Timing
- During `rst` and in the cycle it is sampled: `pc`=RESET_PC, queue empty, state FETCH, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fault`=0.
- First cycle after `rst` deasserts: `imem_req`=1, `imem_addr`=RESET_PC.
- Memory acks in the request cycle: instruction visible on `instr` the next cycle, with 1-cycle latency and 1 instruction/cycle throughput.
- Memory acks k cycles after req: `instr_valid` rises k+1 cycles after req.
- Redirect in cycle n with no outstanding request: `instr_valid`=0 in cycle n+1; `imem_req`=1 with `imem_addr`=`redirect_pc` in cycle n+1.
- Queue full (2 entries) and `stall`=1: `imem_req` stays 0 (unless already raised); outputs hold.

## Test plan
- Reset, then memory always acks immediately and `stall`=0: `instr_pc` sequence 0, 4, 8, 12 on consecutive cycles; `instr_valid` first high in cycle 2 after release.
- `stall`=1 for 5 cycles with immediate acks: exactly 2 entries queued and `imem_req` low. On release, PCs continue 0, 4, 8 in order with no loss or duplication.
- Memory acks 3 cycles late; redirect to 32'h0000_0100 in cycle 1 of the wait: old ack data dropped; next request addr 32'h100; first valid `instr_pc`=32'h100.
- Redirect and ack in the same cycle: acked word never appears; next `imem_addr`=`redirect_pc`.
- RESET_PC=32'hFFFF_FFF8 with immediate acks: `instr_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 32'h0000_0102: `fault`=1 next cycle, `instr_valid`=0, no further requests; `rst` clears `fault` and fetching resumes at RESET_PC.
